// File: rtl/gobackn_pkg.sv
// Shared definitions for the Go-Back-N sender and receiver pair.
package gobackn_pkg;

  localparam int unsigned N           = 4;
  localparam int unsigned SEQ_WIDTH   = 3;
  localparam int unsigned PAYLOAD_W   = 8 - SEQ_WIDTH;
  localparam int unsigned SEQ_LSB     = 0;
  localparam int unsigned PAYLOAD_LSB = SEQ_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GOBACK = 2'd2
  } sender_state_t;

endpackage

// File: rtl/gobackn_frame_buf.sv
// Payload storage for unacknowledged frames: one write port (tail), one async read port (next).
module gobackn_frame_buf import gobackn_pkg::*; #(
  parameter int unsigned Depth = N,
  parameter int unsigned Width = PAYLOAD_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [$clog2(Depth)-1:0] i_waddr,
  input  logic [Width-1:0]         i_wdata,
  input  logic [$clog2(Depth)-1:0] i_raddr,
  output logic [Width-1:0]         o_rdata
);

  logic [Width-1:0] r_mem [Depth];

  // Entries clear on reset so an idle sender presents an all-zero frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem <= '{default: '0};
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/gobackn_sender.sv
// Go-Back-N transmitter: windowed send, cumulative ack retire, timeout rewind to base.
module gobackn_sender #(
  parameter int unsigned N         = gobackn_pkg::N,
  parameter int unsigned SEQ_WIDTH = gobackn_pkg::SEQ_WIDTH,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8-SEQ_WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [SEQ_WIDTH-1:0]   ack_in,
  input  logic                   ack_valid,
  output logic [SEQ_WIDTH-1:0]   outstanding,
  output logic                   timeout_pulse
);
  import gobackn_pkg::*;

  localparam int unsigned PayW   = 8 - SEQ_WIDTH;
  localparam int unsigned IdxW   = $clog2(N);
  localparam int unsigned TimerW = $clog2(TIMEOUT);

  sender_state_t        r_state, w_state_d;
  logic [SEQ_WIDTH-1:0] r_base, w_base_d;
  logic [SEQ_WIDTH-1:0] r_next, w_next_d;
  logic [SEQ_WIDTH-1:0] r_tail, w_tail_d;
  logic [TimerW-1:0]    r_timer, w_timer_d;

  logic [SEQ_WIDTH-1:0] w_occ;
  logic [SEQ_WIDTH-1:0] w_inflight;
  logic [SEQ_WIDTH-1:0] w_ack_dist;
  logic                 w_ack_ok;
  logic                 w_accept;
  logic                 w_fire;
  logic                 w_timer_exp;
  logic                 w_goback;
  logic [PayW-1:0]      w_rdata;

  assign w_occ      = r_tail - r_base;
  assign w_inflight = r_next - r_base;
  assign w_ack_dist = ack_in - r_base;

  // Only acks that retire at least one sent frame count; duplicates and acks past next drop.
  assign w_ack_ok = ack_valid && (r_state != GOBACK) && (w_ack_dist != '0) &&
                    (w_ack_dist <= w_inflight);

  assign in_ready = (r_state != GOBACK) && (w_occ < SEQ_WIDTH'(N)) && !reset;
  assign w_accept = in_valid && in_ready;

  assign tx_valid = (r_state == ACTIVE) && (r_next != r_tail);
  assign w_fire   = tx_valid && tx_ready;
  assign tx_data  = {w_rdata, r_next};

  // A same-cycle ack beats the timeout.
  assign w_timer_exp = (r_state == ACTIVE) && (r_timer == TimerW'(TIMEOUT - 1));
  assign w_goback    = w_timer_exp && !w_ack_ok;

  assign outstanding   = w_inflight;
  assign timeout_pulse = (r_state == GOBACK);

  gobackn_frame_buf #(
    .Depth (N),
    .Width (PayW)
  ) u_frame_buf (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_accept),
    .i_waddr (r_tail[IdxW-1:0]),
    .i_wdata (in_data),
    .i_raddr (r_next[IdxW-1:0]),
    .o_rdata (w_rdata)
  );

  // Pointer and timer next-state; go-back rewinds next even if a frame fires this cycle.
  always_comb begin
    w_base_d  = w_ack_ok ? ack_in : r_base;
    w_tail_d  = w_accept ? r_tail + SEQ_WIDTH'(1) : r_tail;
    w_next_d  = r_next;
    w_timer_d = '0;
    if (w_goback) begin
      w_next_d = r_base;
    end else if (w_fire) begin
      w_next_d = r_next + SEQ_WIDTH'(1);
    end
    if (w_goback || w_ack_ok) begin
      w_timer_d = '0;
    end else if ((r_state == ACTIVE) && (r_next != r_base)) begin
      w_timer_d = r_timer + TimerW'(1);
    end
  end

  // State transitions evaluated on post-update pointers so a new payload sends next cycle.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_tail_d != w_base_d) w_state_d = ACTIVE;
      end
      ACTIVE: begin
        if (w_goback) begin
          w_state_d = GOBACK;
        end else if (w_tail_d == w_base_d) begin
          w_state_d = IDLE;
        end
      end
      GOBACK: begin
        w_state_d = ACTIVE;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset discards the whole window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_next  <= '0;
      r_tail  <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_d;
      r_base  <= w_base_d;
      r_next  <= w_next_d;
      r_tail  <= w_tail_d;
      r_timer <= w_timer_d;
    end
  end

endmodule

// File: tb/tb_gobackn_sender.sv
// Directed bench for gobackn_sender (N=4, SEQ_WIDTH=3, TIMEOUT=16).
module tb_gobackn_sender;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [2:0] ack_in;
  logic       ack_valid;
  logic [2:0] outstanding;
  logic       timeout_pulse;

  int n_checks = 0;
  int n_fails  = 0;
  int cnt;
  int seen;

  logic [7:0] first_exp [4];
  logic [7:0] wrap_exp [10];

  always #5 clk = ~clk;

  gobackn_sender #(
    .N         (4),
    .SEQ_WIDTH (3),
    .TIMEOUT   (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .ack_in        (ack_in),
    .ack_valid     (ack_valid),
    .outstanding   (outstanding),
    .timeout_pulse (timeout_pulse)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    first_exp = '{8'h08, 8'h11, 8'h1A, 8'h23};
    wrap_exp  = '{8'h08, 8'h21, 8'h3A, 8'h53, 8'h6C, 8'h85, 8'h9E, 8'hB7, 8'hC8, 8'hE1};
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    tx_ready  = 1'b1;
    ack_in    = '0;
    ack_valid = 1'b0;

    // Reset values
    tick();
    tick();
    check_eq("rst_in_ready_low", in_ready, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("rst_in_ready_high", in_ready, 1'b1);
    check_eq("rst_tx_valid", tx_valid, 1'b0);
    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_outstanding", outstanding, 3'd0);
    check_eq("rst_pulse", timeout_pulse, 1'b0);

    // Fill the window back to back
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 5'(i + 1);
      tick();
      check_eq("fill_tx_valid", tx_valid, 1'b1);
      check_eq("fill_tx_data", tx_data, first_exp[i]);
    end
    check_eq("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    tick();
    check_eq("full_outstanding", outstanding, 3'd4);
    check_eq("full_tx_valid", tx_valid, 1'b0);
    check_eq("full_in_ready2", in_ready, 1'b0);

    // Partial ack frees two slots
    ack_valid = 1'b1;
    ack_in    = 3'd2;
    tick();
    ack_valid = 1'b0;
    check_eq("ack2_outstanding", outstanding, 3'd2);
    check_eq("ack2_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = 5'h05;
    tick();
    in_valid = 1'b0;
    check_eq("seq4_tx_data", tx_data, 8'h2C);
    check_eq("seq4_tx_valid", tx_valid, 1'b1);
    tick();
    check_eq("seq4_outstanding", outstanding, 3'd3);

    // Timeout 16 edges after the last accepted ack, then resend seq 2,3,4
    cnt = 2;
    while (!timeout_pulse && cnt < 40) begin
      tick();
      cnt++;
    end
    check_eq("to_latency", cnt, 16);
    check_eq("to_goback_tx_valid", tx_valid, 1'b0);
    tick();
    check_eq("to_pulse_one_cycle", timeout_pulse, 1'b0);
    check_eq("resend_seq2", tx_data, 8'h1A);
    check_eq("resend_valid", tx_valid, 1'b1);
    tick();
    check_eq("resend_seq3", tx_data, 8'h23);
    tick();
    check_eq("resend_seq4", tx_data, 8'h2C);
    tick();
    check_eq("resend_done_valid", tx_valid, 1'b0);
    check_eq("resend_outstanding", outstanding, 3'd3);
    ack_valid = 1'b1;
    ack_in    = 3'd5;
    tick();
    ack_valid = 1'b0;
    check_eq("ack5_outstanding", outstanding, 3'd0);

    // Sequence wrap with duplicate and out-of-range acks
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 5'(i * 3 + 1);
      tick();
      in_valid = 1'b0;
      check_eq("wrap_tx_data", tx_data, wrap_exp[i]);
      tick();
      check_eq("wrap_sent_outstanding", outstanding, 3'd1);
      if (i == 3) begin
        ack_valid = 1'b1;
        ack_in    = 3'd3;
        tick();
        check_eq("dup_ack_outstanding", outstanding, 3'd1);
        ack_in = 3'd6;
        tick();
        check_eq("far_ack_outstanding", outstanding, 3'd1);
      end
      ack_valid = 1'b1;
      ack_in    = 3'((i + 1) % 8);
      tick();
      ack_valid = 1'b0;
      check_eq("wrap_acked_outstanding", outstanding, 3'd0);
    end

    // Ack in the timer-expiry cycle restarts the timer
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 5'(i + 6);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check_eq("race_outstanding3", outstanding, 3'd3);
    ack_valid = 1'b1;
    ack_in    = 3'd1;
    tick();
    ack_valid = 1'b0;
    seen = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (timeout_pulse) seen++;
      if (k == 15) begin
        ack_valid = 1'b1;
        ack_in    = 3'd2;
      end
    end
    tick();
    ack_valid = 1'b0;
    if (timeout_pulse) seen++;
    check_eq("race_no_pulse", seen, 0);
    check_eq("race_outstanding1", outstanding, 3'd1);
    cnt = 0;
    while (!timeout_pulse && cnt < 40) begin
      tick();
      cnt++;
    end
    check_eq("race_restart_latency", cnt, 16);
    tick();
    check_eq("race_resend_seq2", tx_data, 8'h42);
    tick();
    ack_valid = 1'b1;
    ack_in    = 3'd3;
    tick();
    ack_valid = 1'b0;
    check_eq("race_cleared", outstanding, 3'd0);

    // Reset with three frames outstanding and the link stalled
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 5'(i + 9);
      tick();
    end
    in_valid = 1'b0;
    tx_ready = 1'b0;
    check_eq("stall_outstanding", outstanding, 3'd3);
    check_eq("stall_tx_data", tx_data, 8'h63);
    tick();
    check_eq("stall_hold_data", tx_data, 8'h63);
    check_eq("stall_hold_valid", tx_valid, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("midrst_in_ready", in_ready, 1'b0);
    tick();
    check_eq("midrst_tx_valid", tx_valid, 1'b0);
    check_eq("midrst_outstanding", outstanding, 3'd0);
    check_eq("midrst_tx_data", tx_data, 8'h00);
    reset    = 1'b0;
    tx_ready = 1'b1;
    seen     = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (tx_valid || timeout_pulse) seen++;
    end
    check_eq("midrst_no_resend", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/gobackn_sender.md
# gobackn_sender

Go-Back-N transmitter feeding the receiver stage. Accepts 5-bit payloads from a local source and frames each as {payload, seq}, with the 3-bit sequence number in bits [2:0]. Holds up to N unacknowledged frames, retires them on cumulative acknowledgments, and on timeout rewinds to the oldest outstanding frame and retransmits the whole window.

## Interface
- Parameters:
  - N, default 4: window size. Must be a power of two and ≤ 2^SEQ_WIDTH − 1.
  - SEQ_WIDTH, default 3: sequence number width.
  - TIMEOUT, default 16: cycles without a new ack before go-back. Must be ≥ 2.
- Ports:
  - clk, in, 1: clock. One clock domain; everything is sampled on the rising edge.
  - reset, in, 1: synchronous, active-high reset.
  - in_data, in, 8−SEQ_WIDTH (5): payload from the source.
  - in_valid, in, 1: in_data is valid.
  - in_ready, out, 1: the sender accepts in_data this cycle.
  - tx_data, out, 8: frame {payload[4:0], seq[2:0]}.
  - tx_valid, out, 1: tx_data is valid.
  - tx_ready, in, 1: link accepts the frame. Tie to 1 for a direct receiver connection.
  - ack_in, in, SEQ_WIDTH: cumulative ack, equal to the receiver's next expected sequence number.
  - ack_valid, in, 1: ack_in is valid this cycle.
  - outstanding, out, SEQ_WIDTH: number of frames sent but not yet acked.
  - timeout_pulse, out, 1: one-cycle strobe when a go-back occurs.

## Operation
- Pointers, all SEQ_WIDTH bits wide and wrapping mod 2^SEQ_WIDTH:
  - base: oldest unacked frame.
  - next: next sequence number to send.
  - tail: next free slot.
  - Invariant: base ≤ next ≤ tail in modular distance, and tail − base ≤ N.
- Buffer: payload storage with N entries, indexed by seq[log2 N − 1:0].
- Accept:
  - in_ready = (state ≠ GOBACK) && (tail − base) < N && !reset.
  - When in_valid && in_ready: buf[tail] ← in_data, tail ← tail+1.
- Transmit:
  - tx_valid = (state == ACTIVE) && next ≠ tail.
  - tx_data = {buf[next], next}.
  - When tx_valid && tx_ready: next ← next+1.
  - Frames are held stable while tx_ready = 0.
- Ack:
  - Let d = (ack_in − base) mod 2^SEQ_WIDTH. The ack is accepted iff ack_valid && state ≠ GOBACK && 1 ≤ d ≤ (next − base).
  - On acceptance: base ← ack_in and timer ← 0.
  - Any other ack (d = 0 duplicate, or beyond next) is ignored.
- Timer:
  - Increments each cycle while state == ACTIVE && next ≠ base.
  - Held at 0 when next == base.
- State machine, encoded as sender_state_t:
  - IDLE → ACTIVE when tail ≠ base.
  - ACTIVE → IDLE when tail == base after updates.
  - ACTIVE → GOBACK when timer == TIMEOUT−1 and no ack is accepted that cycle. On this transition: next ← base, timer ← 0, and timeout_pulse is 1 in the following cycle.
  - GOBACK → ACTIVE unconditionally after 1 cycle.
- outstanding = next − base.
- Simultaneous events:
  - Ack accepted in the timeout cycle: the ack wins, no go-back, timer ← 0.
  - tx fire in the timeout cycle: the go-back wins, and next ← base (the fired frame will be resent).
  - Accept, tx fire and ack in the same cycle: all three apply independently.
  - Accept with a full window: in_ready = 0. An ack in the same cycle frees space from the next cycle only.
- Reset mid-operation: all pointers, the timer and the state clear. Buffered frames are discarded and no retransmission follows.

## Timing
- Reset values:
  - in_ready 0 while reset is high, then 1 in the first cycle after release.
  - tx_valid 0, tx_data 8'h00, outstanding 0, timeout_pulse 0, state IDLE.
- A payload accepted at edge k appears on tx_data/tx_valid in cycle k+1, provided next == tail.
- With tx_ready held at 1, back-to-back frames go out at 1 per cycle until the window is exhausted.
- An ack accepted at edge k: base updates at k, and in_ready can rise in cycle k+1.
- Go-back: timeout_pulse is high for exactly 1 cycle (the GOBACK cycle). The frame with seq = base is on tx_data in the following cycle.
- No combinational path from ack_in to tx_data.

## Structure
- Package gobackn_pkg:
  - Constants: N, SEQ_WIDTH, PAYLOAD_W = 8 − SEQ_WIDTH, SEQ_LSB = 0, PAYLOAD_LSB = SEQ_WIDTH.
  - sender_state_t {IDLE, ACTIVE, GOBACK}.
  - Shared by the receiver.
- Sub-module gobackn_frame_buf: N × PAYLOAD_W register file with one write port (tail) and one asynchronous read port (next). The pointer/timer FSM stays in gobackn_sender.

## Test plan
- Reset, then push payloads 5'h01..5'h04 with tx_ready = 1 → tx_data 8'h08, 8'h11, 8'h1A, 8'h23 (seq 0..3) on consecutive cycles. Then in_ready = 0 and outstanding = 4.
- Ack ack_in = 2 → base = 2, outstanding = 2, in_ready = 1. Push 5'h05 → frame 8'h2C (seq 4).
- No ack for TIMEOUT cycles after the sends → timeout_pulse for 1 cycle, then frames with seq 2, 3, 4 are resent in order with the same payloads.
- Wrap: send and ack 10 frames → seq goes 0..7, 0, 1. Ack ack_in = 0 after seq 7 is accepted. A duplicate ack (ack_in == base) is ignored and outstanding is unchanged.
- Ack arriving in the same cycle timer == TIMEOUT−1 → no timeout_pulse, and the timer restarts.
- Assert reset with 3 frames outstanding and tx_ready = 0 → next cycle tx_valid = 0 and outstanding = 0. No retransmission afterwards.
